// File: rtl/ysyx_041461_mem_access_pkg.sv
// Shared op codes, trap codes and FSM encoding for the MEM-stage load/store unit.
package ysyx_041461_mem_access_pkg;

    localparam logic [3:0] TrapNop           = 4'd0;
    localparam logic [3:0] TrapLoadMisalign  = 4'd4;
    localparam logic [3:0] TrapStoreMisalign = 4'd6;

    typedef enum logic [3:0] {
        MemNop = 4'd0,
        MemLb  = 4'd1,
        MemLh  = 4'd2,
        MemLw  = 4'd3,
        MemLd  = 4'd4,
        MemLbu = 4'd5,
        MemLhu = 4'd6,
        MemLwu = 4'd7,
        MemSb  = 4'd8,
        MemSh  = 4'd9,
        MemSw  = 4'd10,
        MemSd  = 4'd11
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRsp,
        StDone
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= MemLb) && (op <= MemLwu);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MemSb) && (op <= MemSd);
    endfunction

    // log2 of the access size in bytes; non-memory ops fall into the byte bucket
    function automatic logic [1:0] size_log2(input logic [3:0] op);
        case (op)
            MemLh, MemLhu, MemSh: return 2'd1;
            MemLw, MemLwu, MemSw: return 2'd2;
            MemLd, MemSd:         return 2'd3;
            default:              return 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [2:0] off);
        case (size_log2(op))
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input logic [3:0] op);
        case (size_log2(op))
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_041461_load_ext.sv
// Selects the addressed lane of an 8-byte-aligned read word and sign/zero-extends it.
module ysyx_041461_load_ext
    import ysyx_041461_mem_access_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      offset_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] lane;

    always_comb begin
        lane = rdata_i >> {offset_i, 3'b000};
        case (op_i)
            MemLb:   data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            MemLh:   data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            MemLw:   data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
            MemLbu:  data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
            MemLhu:  data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
            MemLwu:  data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
            MemLd:   data_o = lane;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_041461_mem_access.sv
// MEM-stage load/store unit: one bus transaction per aligned load/store, stalling the
// pipeline until the response returns; non-memory ops pass through combinationally.
module ysyx_041461_mem_access
    import ysyx_041461_mem_access_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              flush_i,
    input  logic [3:0]        mem_ctrl_i,
    input  logic [3:0]        trap_in_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              stall_req_o,
    output logic              out_valid_o,
    output logic [3:0]        trap_out_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic              dmem_wen_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [MASK_W-1:0] dmem_wmask_o,
    input  logic              dmem_rsp_valid_i,
    input  logic [XLEN-1:0]   dmem_rsp_rdata_i
);

    state_e          state_q, state_d;
    logic            killed_q, killed_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] ext_data;
    logic [2:0]      offset;
    logic            op_load, op_store, op_mem;

    assign offset   = addr_i[2:0];
    assign op_load  = is_load(mem_ctrl_i);
    assign op_store = is_store(mem_ctrl_i);
    assign op_mem   = op_load | op_store;

    ysyx_041461_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .rdata_i (rdata_q),
        .offset_i(offset),
        .op_i    (mem_ctrl_i),
        .data_o  (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            killed_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        killed_d         = killed_q;
        rdata_d          = rdata_q;
        stall_req_o      = 1'b0;
        out_valid_o      = 1'b0;
        trap_out_o       = trap_in_i;
        load_data_o      = '0;
        dmem_req_valid_o = 1'b0;
        dmem_addr_o      = '0;
        dmem_wen_o       = 1'b0;
        dmem_wdata_o     = '0;
        dmem_wmask_o     = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    if (!op_mem) begin
                        out_valid_o = !flush_i;
                    end else if (trap_in_i != TrapNop) begin
                        out_valid_o = 1'b1;
                    end else if (misaligned(mem_ctrl_i, offset)) begin
                        out_valid_o = 1'b1;
                        trap_out_o  = op_store ? TrapStoreMisalign : TrapLoadMisalign;
                    end else if (!flush_i) begin
                        stall_req_o = 1'b1;
                        killed_d    = 1'b0;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                // Inputs are frozen by the stall, so request fields come straight from them.
                stall_req_o      = 1'b1;
                dmem_req_valid_o = 1'b1;
                dmem_addr_o      = {addr_i[XLEN-1:3], 3'b000};
                dmem_wen_o       = op_store;
                dmem_wdata_o     = wdata_i << {offset, 3'b000};
                dmem_wmask_o     = op_store ? byte_mask(mem_ctrl_i) << offset : '0;
                if (flush_i) killed_d = 1'b1;
                if (dmem_req_ready_i) state_d = StRsp;
            end
            StRsp: begin
                stall_req_o = 1'b1;
                if (flush_i) killed_d = 1'b1;
                if (dmem_rsp_valid_i) begin
                    rdata_d = dmem_rsp_rdata_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid_o = !killed_q;
                load_data_o = op_load ? ext_data : '0;
                killed_d    = 1'b0;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs must read as idle for the whole reset window, whatever the inputs do.
        if (rst) begin
            stall_req_o      = 1'b0;
            out_valid_o      = 1'b0;
            trap_out_o       = trap_in_i;
            load_data_o      = '0;
            dmem_req_valid_o = 1'b0;
            dmem_addr_o      = '0;
            dmem_wen_o       = 1'b0;
            dmem_wdata_o     = '0;
            dmem_wmask_o     = '0;
        end
    end

endmodule

// File: tb/tb_ysyx_041461_mem_access.sv
// Self-checking bench for ysyx_041461_mem_access: directed table, reset corner case,
// and randomized transactions against a behavioural model.
module tb_ysyx_041461_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush;
    logic [3:0]  mem_ctrl, trap_in, trap_out;
    logic [63:0] addr, wdata, load_data, dmem_addr, dmem_wdata, dmem_rsp_rdata;
    logic        stall_req, out_valid, dmem_req_valid, dmem_req_ready, dmem_wen;
    logic        dmem_rsp_valid;
    logic [7:0]  dmem_wmask;

    int n_vec = 0;
    int n_err = 0;

    ysyx_041461_mem_access #(
        .XLEN  (64),
        .MASK_W(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid_i      (in_valid),
        .flush_i         (flush),
        .mem_ctrl_i      (mem_ctrl),
        .trap_in_i       (trap_in),
        .addr_i          (addr),
        .wdata_i         (wdata),
        .stall_req_o     (stall_req),
        .out_valid_o     (out_valid),
        .trap_out_o      (trap_out),
        .load_data_o     (load_data),
        .dmem_req_valid_o(dmem_req_valid),
        .dmem_req_ready_i(dmem_req_ready),
        .dmem_addr_o     (dmem_addr),
        .dmem_wen_o      (dmem_wen),
        .dmem_wdata_o    (dmem_wdata),
        .dmem_wmask_o    (dmem_wmask),
        .dmem_rsp_valid_i(dmem_rsp_valid),
        .dmem_rsp_rdata_i(dmem_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [3:0]  trap;
        bit          flush_idle;
        bit          flush_rsp;
        int          ready_wait;
        int          rsp_wait;
        bit          exp_req;
        bit          exp_ov;
        logic [3:0]  exp_trap;
        logic [63:0] exp_ld;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, wd, rd,
                                input logic [3:0] tr, input bit fi, fr, input int rw, sw,
                                input bit er, eov, input logic [3:0] et,
                                input logic [63:0] eld, input logic [7:0] ewm,
                                input logic [63:0] ewd);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = wd; v.rdata = rd; v.trap = tr;
        v.flush_idle = fi; v.flush_rsp = fr; v.ready_wait = rw; v.rsp_wait = sw;
        v.exp_req = er; v.exp_ov = eov; v.exp_trap = et; v.exp_ld = eld;
        v.exp_wmask = ewm; v.exp_wdata = ewd;
        return v;
    endfunction

    // Reference: access size in bytes, signedness, and the architectural outcome.
    function automatic vec_t model(input logic [3:0] op, input logic [63:0] a, wd, rd,
                                   input logic [3:0] tr, input bit fr, input int rw, sw);
        int          n;
        bit          sgn, st;
        int          off;
        logic [63:0] m, v;
        n = 0;
        case (op)
            4'd1, 4'd5, 4'd8:  n = 1;
            4'd2, 4'd6, 4'd9:  n = 2;
            4'd3, 4'd7, 4'd10: n = 4;
            4'd4, 4'd11:       n = 8;
            default:           n = 0;
        endcase
        sgn = (op >= 4'd1) && (op <= 4'd3);
        st  = (op >= 4'd8) && (op <= 4'd11);
        off = int'(a % 8);
        if (n == 0) return mk(op, a, wd, rd, tr, 0, fr, rw, sw, 0, 1, tr, 0, 0, 0);
        if (tr != 0) return mk(op, a, wd, rd, tr, 0, fr, rw, sw, 0, 1, tr, 0, 0, 0);
        if ((a % n) != 0)
            return mk(op, a, wd, rd, tr, 0, fr, rw, sw, 0, 1, st ? 4'd6 : 4'd4, 0, 0, 0);
        m = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v = (rd >> (8 * off)) & m;
        if (sgn && v[8*n-1]) v = v | ~m;
        if (st) v = 0;
        return mk(op, a, wd, rd, tr, 0, fr, rw, sw, 1, !fr, 4'd0, v,
                  st ? 8'(((1 << n) - 1) << off) : 8'h00, wd << (8 * off));
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int          stalls;
        logic [63:0] da;
        bit          st;
        stalls = 0;
        da     = v.addr & ~64'h7;
        st     = (v.op >= 4'd8) && (v.op <= 4'd11);
        @(posedge clk); #1;
        in_valid = 1; mem_ctrl = v.op; trap_in = v.trap; addr = v.addr; wdata = v.wdata;
        flush = v.flush_idle;
        @(negedge clk);
        check({tag, " idle req_valid"}, dmem_req_valid, 0);
        if (v.exp_req) begin
            check({tag, " idle stall"}, stall_req, 1);
            check({tag, " idle out_valid"}, out_valid, 0);
            if (stall_req) stalls++;
            for (int i = 0; i <= v.ready_wait; i++) begin
                @(posedge clk); #1;
                flush = 0;
                dmem_req_ready = (i == v.ready_wait);
                // Stray response strobes while requesting must be ignored.
                dmem_rsp_valid = (i != v.ready_wait);
                dmem_rsp_rdata = {$urandom, $urandom};
                @(negedge clk);
                if (stall_req) stalls++;
                check({tag, " req_valid"}, dmem_req_valid, 1);
                check({tag, " req addr"}, dmem_addr, da);
                check({tag, " req wen"}, dmem_wen, st);
                if (st) begin
                    check({tag, " req wmask"}, dmem_wmask, v.exp_wmask);
                    check({tag, " req wdata"}, dmem_wdata, v.exp_wdata);
                end
            end
            for (int j = 0; j <= v.rsp_wait; j++) begin
                @(posedge clk); #1;
                dmem_req_ready = 0;
                flush = v.flush_rsp && (j == 0);
                dmem_rsp_valid = (j == v.rsp_wait);
                dmem_rsp_rdata = (j == v.rsp_wait) ? v.rdata : {$urandom, $urandom};
                @(negedge clk);
                if (stall_req) stalls++;
                check({tag, " rsp req_valid"}, dmem_req_valid, 0);
                check({tag, " rsp out_valid"}, out_valid, 0);
            end
            @(posedge clk); #1;
            dmem_rsp_valid = 0; flush = 0; dmem_rsp_rdata = {$urandom, $urandom};
            @(negedge clk);
            check({tag, " done stall"}, stall_req, 0);
            check({tag, " done out_valid"}, out_valid, v.exp_ov);
            check({tag, " done trap"}, trap_out, v.exp_trap);
            if (v.exp_ov) check({tag, " done load_data"}, load_data, v.exp_ld);
            check({tag, " stall cycles"}, 64'(stalls), 64'(v.ready_wait + v.rsp_wait + 3));
        end else begin
            check({tag, " stall"}, stall_req, 0);
            check({tag, " out_valid"}, out_valid, v.exp_ov);
            check({tag, " trap"}, trap_out, v.exp_trap);
            check({tag, " load_data"}, load_data, 0);
        end
        @(posedge clk); #1;
        in_valid = 0; flush = 0; mem_ctrl = 0; trap_in = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; in_valid = 1; flush = 0; mem_ctrl = 4'd0; trap_in = 4'd5;
        addr = 0; wdata = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
        #2;
        check("reset stall", stall_req, 0);
        check("reset out_valid", out_valid, 0);
        check("reset req_valid", dmem_req_valid, 0);
        check("reset load_data", load_data, 0);
        check("reset trap passthrough", trap_out, 4'd5);
        @(posedge clk); #1;
        rst = 0; in_valid = 0; trap_in = 0;

        //            op     addr            wdata                  rdata
        //            trap fi fr rw sw  req ov trap ld                    wmask  wdata
        tbl.push_back(mk(4'd3, 64'h8000_0104, 0, 64'hFFFF_FFFF_8000_0000,
                         0, 0, 0, 0, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0));
        tbl.push_back(mk(4'd9, 64'h8000_0006, 64'hABCD, 0,
                         0, 0, 0, 0, 0, 1, 1, 0, 0, 8'hC0, 64'hABCD_0000_0000_0000));
        tbl.push_back(mk(4'd4, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd4, 0, 0, 0));
        tbl.push_back(mk(4'd10, 64'h8000_0002, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd6, 0, 0, 0));
        tbl.push_back(mk(4'd3, 64'h8000_0100, 0, 64'h1234_5678_7654_3210,
                         0, 0, 0, 4, 2, 1, 1, 0, 64'h0000_0000_7654_3210, 0, 0));
        tbl.push_back(mk(4'd4, 64'h8000_0008, 0, 64'h1111_2222_3333_4444,
                         0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd1, 64'h8000_0007, 0, 64'h80FF_0000_0000_0000,
                         0, 0, 0, 0, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0));
        tbl.push_back(mk(4'd6, 64'h0000_0002, 0, 64'h0000_0000_BEEF_0000,
                         0, 0, 0, 1, 0, 1, 1, 0, 64'h0000_0000_0000_BEEF, 0, 0));
        tbl.push_back(mk(4'd2, 64'h0000_0002, 0, 64'h0000_0000_BEEF_0000,
                         0, 0, 0, 0, 1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_BEEF, 0, 0));
        tbl.push_back(mk(4'd7, 64'h0000_0004, 0, 64'h8000_0001_0000_0000,
                         0, 0, 0, 0, 0, 1, 1, 0, 64'h0000_0000_8000_0001, 0, 0));
        tbl.push_back(mk(4'd4, 64'h0000_0010, 0, 64'h0123_4567_89AB_CDEF,
                         0, 0, 0, 0, 0, 1, 1, 0, 64'h0123_4567_89AB_CDEF, 0, 0));
        tbl.push_back(mk(4'd8, 64'h0000_0005, 64'h77, 0,
                         0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h20, 64'h0000_7700_0000_0000));
        tbl.push_back(mk(4'd11, 64'h0000_0008, 64'hDEAD_BEEF_CAFE_F00D, 0,
                         0, 0, 0, 2, 0, 1, 1, 0, 0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D));
        tbl.push_back(mk(4'd0, 64'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'd13, 64'h0000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'd3, 64'h0000_0008, 0, 0, 4'd2, 0, 0, 0, 0, 0, 1, 4'd2, 0, 0, 0));
        tbl.push_back(mk(4'd3, 64'h0000_0008, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd0, 64'h0000_0008, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd6, 64'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd4, 0, 0, 0));

        foreach (tbl[k]) run_txn(tbl[k], $sformatf("t%0d", k));

        // Reset while waiting for a response: outputs drop at once, next access is clean.
        @(posedge clk); #1;
        in_valid = 1; mem_ctrl = 4'd3; addr = 64'h100; trap_in = 0; flush = 0;
        @(negedge clk);
        @(posedge clk); #1;
        dmem_req_ready = 1;
        @(negedge clk);
        check("rst-seq req_valid", dmem_req_valid, 1);
        @(posedge clk); #1;
        dmem_req_ready = 0;
        @(negedge clk);
        check("rst-seq rsp stall", stall_req, 1);
        #1 rst = 1;
        #1;
        check("rst-seq stall", stall_req, 0);
        check("rst-seq out_valid", out_valid, 0);
        check("rst-seq req_valid low", dmem_req_valid, 0);
        check("rst-seq load_data", load_data, 0);
        @(posedge clk); #1;
        rst = 0; in_valid = 0; mem_ctrl = 0;
        run_txn(mk(4'd5, 64'h8000_0003, 0, 64'h0000_0000_8000_0000,
                   0, 0, 0, 0, 0, 1, 1, 0, 64'h80, 0, 0), "rst-seq lbu");

        for (int r = 0; r < 80; r++) begin
            logic [3:0]  op, tr;
            logic [63:0] a, wd, rd;
            op = 4'($urandom_range(0, 15));
            a  = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 255))};
            wd = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            tr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            run_txn(model(op, a, wd, rd, tr, $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                    $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
